// File: rtl/chunk_serial_adder_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : chunk_serial_adder_if
// Description : Operand request / result handshake bundle for the
//               chunk-serial adder. The slave side is the adder itself.
// Revision    : 1.0 - initial release
// ============================================================================
interface chunk_serial_adder_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             in_sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             is_overflowed;

    // Requester: supplies operands and consumes results
    modport master (
        output in_valid, in_a, in_b, in_sub, out_ready,
        input  in_ready, out_valid, sum, cout, is_overflowed
    );

    // Adder: accepts operands and presents results
    modport slave (
        input  in_valid, in_a, in_b, in_sub, out_ready,
        output in_ready, out_valid, sum, cout, is_overflowed
    );
endinterface
`default_nettype wire

// File: rtl/chunk_serial_adder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : chunk_serial_adder
// Description : Multi-cycle adder/subtractor that processes CHUNK bits per
//               clock, LSB chunk first, with valid/ready handshakes on both
//               the operand and result sides.
// Revision    : 1.0 - initial release
// ============================================================================
module chunk_serial_adder #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    chunk_serial_adder_if.slave  bus
);
    localparam int N  = WIDTH / CHUNK;
    // Keep the counter at least one bit wide so N = 1 is still legal
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] K_LAST = CW'(N - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;       // B already inverted for subtraction
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             carry_q, carry_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;
    logic [CW-1:0]    k_q, k_d;

    logic [CHUNK-1:0] w_a_chunk;
    logic [CHUNK-1:0] w_b_chunk;
    logic [CHUNK:0]   w_chunk_sum;

    // Current chunk slice and its sum with the running carry
    assign w_a_chunk   = a_q[k_q*CHUNK +: CHUNK];
    assign w_b_chunk   = b_q[k_q*CHUNK +: CHUNK];
    assign w_chunk_sum = {1'b0, w_a_chunk} + {1'b0, w_b_chunk}
                       + {{CHUNK{1'b0}}, carry_q};

    // Next-state and datapath update; everything holds unless the state acts
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        k_d     = k_q;
        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    a_d     = bus.in_a;
                    b_d     = bus.in_sub ? ~bus.in_b : bus.in_b;
                    carry_d = bus.in_sub;   // +1 completes the two's complement
                    k_d     = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                sum_d[k_q*CHUNK +: CHUNK] = w_chunk_sum[CHUNK-1:0];
                carry_d = w_chunk_sum[CHUNK];
                if (k_q == K_LAST) begin
                    // The top bit of this last chunk is the result sign bit
                    cout_d  = w_chunk_sum[CHUNK];
                    ovf_d   = (a_q[WIDTH-1] == b_q[WIDTH-1]) &&
                              (w_chunk_sum[CHUNK-1] != a_q[WIDTH-1]);
                    k_d     = '0;
                    state_d = DONE;
                end else begin
                    k_d = k_q + CW'(1);
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset discards any operation in flight
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            k_q     <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
            k_q     <= k_d;
        end
    end

    assign bus.in_ready      = (state_q == IDLE);
    assign bus.out_valid     = (state_q == DONE);
    assign bus.sum           = sum_q;
    assign bus.cout          = cout_q;
    assign bus.is_overflowed = ovf_q;

endmodule
`default_nettype wire

// File: doc/chunk_serial_adder.md
CHUNK_SERIAL_ADDER -- requirements
Module: chunk_serial_adder

Interface
REQ-001 Parameter WIDTH, default 16, operand/result width in bits; SHALL be >= 2.
REQ-002 Parameter CHUNK, default 4, bits added per cycle; WIDTH SHALL be an integer multiple of CHUNK; N = WIDTH/CHUNK.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 in_valid  input  1  operand request valid.
REQ-006 in_ready  output  1  block can accept operands.
REQ-007 in_a  input  WIDTH  operand A (two's complement or unsigned).
REQ-008 in_b  input  WIDTH  operand B.
REQ-009 in_sub  input  1  0 = A+B, 1 = A-B.
REQ-010 out_valid  output  1  result valid.
REQ-011 out_ready  input  1  consumer accepts result.
REQ-012 sum  output  WIDTH  result, modulo 2^WIDTH.
REQ-013 cout  output  1  carry out of MSB (for subtract: 1 = no borrow).
REQ-014 is_overflowed  output  1  signed two's-complement overflow of the operation.

Function
REQ-015 States SHALL be IDLE, RUN, DONE; in_ready = 1 only in IDLE; out_valid = 1 only in DONE.
REQ-016 IDLE: on an edge with in_valid=1, SHALL capture A = in_a, B' = in_b (in_sub=0) or ~in_b (in_sub=1), carry = in_sub, chunk counter = 0, and go to RUN; otherwise stay.
REQ-017 RUN: each edge SHALL add chunk k (bits k*CHUNK..k*CHUNK+CHUNK-1) of A and B' plus carry, write the CHUNK-bit result into the same chunk of sum, update carry, increment k, starting at k=0 (LSB chunk).
REQ-018 After the edge processing chunk N-1, SHALL go to DONE; out_valid SHALL therefore rise exactly N cycles after the accepting edge.
REQ-019 On entry to DONE: cout = final carry; is_overflowed = (A[WIDTH-1] == B'[WIDTH-1]) && (sum[WIDTH-1] != A[WIDTH-1]).
REQ-020 DONE: sum, cout, is_overflowed SHALL remain stable while out_ready=0; on an edge with out_ready=1 SHALL go to IDLE.
REQ-021 in_valid, in_a, in_b, in_sub SHALL be ignored outside IDLE; no operands are queued.
REQ-022 Back-to-back throughput with in_valid and out_ready held high SHALL be one result per N+2 cycles (1 IDLE, N RUN, 1 DONE).
REQ-023 sum, cout, is_overflowed SHALL hold their last DONE values in IDLE and during RUN until overwritten chunk-wise; consumers SHALL only sample them when out_valid=1.
REQ-024 CHUNK = WIDTH (N=1) SHALL be legal: one RUN cycle.
REQ-025 Counter width SHALL be sufficient for N; no wrap-around beyond N-1 occurs.

Reset
REQ-026 rst=1 SHALL immediately, independent of clk, force state IDLE, sum = 0, cout = 0, is_overflowed = 0, counter = 0, carry = 0.
REQ-027 During reset in_ready = 1, out_valid = 0; rst asserted mid-RUN or in DONE SHALL discard the operation with no result ever presented.
REQ-028 First acceptance possible on the first rising edge with rst=0.

Verification (WIDTH=16, CHUNK=4, N=4)
REQ-029 Add 0x7FFF + 0x0001, out_ready=1 -> out_valid rises 4 cycles after accept; sum=0x8000, cout=0, is_overflowed=1.
REQ-030 Add 0xFFFF + 0x0001 -> sum=0x0000, cout=1, is_overflowed=0; subtract 0x0005 - 0x0007 -> sum=0xFFFE, cout=0, is_overflowed=0.
REQ-031 Subtract 0x8000 - 0x0001 -> sum=0x7FFF, cout=1, is_overflowed=1.
REQ-032 Backpressure: out_ready=0 for 10 cycles in DONE while in_valid=1 with new operands -> outputs unchanged, in_ready=0, new operands not captured; result retires on first out_ready=1 edge.
REQ-033 Reset asynchronously during the 2nd RUN cycle -> out_valid=0, in_ready=1, sum=0 before next edge; no stale result appears later.
REQ-034 Stream of 3 operand sets with in_valid=out_ready=1 -> results in order, one every 6 cycles; repeat with CHUNK=16 (1 RUN cycle, period 3) and compare against a reference model over random operands.
